// File: rtl/unit2_pkg.sv
// unit2_pkg: shared display widths, blank/glyph codes and the hex digit table.
package unit2_pkg;
  localparam int SEG_W = 8;
  localparam int OPW = 4;
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;
  localparam logic [SEG_W-1:0] SEG_L = 8'hC7;
  localparam logic [SEG_W-1:0] SEG_E = 8'h86;
  localparam logic [SEG_W-1:0] SEG_G = 8'hC2;
  localparam logic [SEG_W-1:0] SEG_DIGIT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
endpackage

// File: rtl/hex_to_7seg.sv
// hex_to_7seg: combinational 4-bit value to active-low {dp,g..a} segment pattern.
module hex_to_7seg
  import unit2_pkg::*;
(
  input  logic [OPW-1:0]   i_val,
  output logic [SEG_W-1:0] o_seg
);
  assign o_seg = SEG_DIGIT[i_val];
endmodule

// File: rtl/unit2_compare_display.sv
// unit2_compare_display: unsigned compare of SW[7:4] vs SW[3:0], shown on HEX5/HEX3/HEX1 and LEDR[2:0].
// UNIT2_GT_GLYPH_EN: when defined, HEX3 shows 'G' for A>B instead of blank.
module unit2_compare_display
  import unit2_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       SW,
  output logic [9:0]       LEDR,
  output logic [SEG_W-1:0] HEX0,
  output logic [SEG_W-1:0] HEX1,
  output logic [SEG_W-1:0] HEX2,
  output logic [SEG_W-1:0] HEX3,
  output logic [SEG_W-1:0] HEX4,
  output logic [SEG_W-1:0] HEX5
);
  logic [OPW-1:0]   w_a, w_b;
  logic [SEG_W-1:0] w_seg_a, w_seg_b, w_glyph, w_gt_glyph;
  logic             w_lt, w_eq, w_gt, w_unused;
  logic [SEG_W-1:0] r_hex1, r_hex3, r_hex5;
  logic [2:0]       r_flags;
  assign w_a = SW[7:4];
  assign w_b = SW[3:0];
  assign w_unused = ^SW[9:8];
  assign w_lt = w_a < w_b;
  assign w_eq = w_a == w_b;
  assign w_gt = w_a > w_b;
`ifdef UNIT2_GT_GLYPH_EN
  assign w_gt_glyph = SEG_G;
`else
  assign w_gt_glyph = SEG_BLANK;
`endif
  assign w_glyph = w_lt ? SEG_L : w_eq ? SEG_E : w_gt_glyph;
  hex_to_7seg u_dec_a (.i_val(w_a), .o_seg(w_seg_a));
  hex_to_7seg u_dec_b (.i_val(w_b), .o_seg(w_seg_b));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hex1  <= SEG_BLANK;
      r_hex3  <= SEG_BLANK;
      r_hex5  <= SEG_BLANK;
      r_flags <= '0;
    end else begin
      r_hex1  <= w_seg_b;
      r_hex3  <= w_glyph;
      r_hex5  <= w_seg_a;
      r_flags <= {w_gt, w_eq, w_lt};
    end
  end
  assign HEX0 = SEG_BLANK;
  assign HEX2 = SEG_BLANK;
  assign HEX4 = SEG_BLANK;
  assign HEX1 = r_hex1;
  assign HEX3 = r_hex3;
  assign HEX5 = r_hex5;
  assign LEDR = {7'b0, r_flags};
endmodule

// File: tb/tb_unit2_compare_display.sv
// tb_unit2_compare_display: randomized and exhaustive checks against a table-driven reference model.
module tb_unit2_compare_display;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] SW = '0;
  logic [9:0] LEDR;
  logic [7:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  int checks = 0;
  int errors = 0;
  logic [7:0] digit [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
`ifdef UNIT2_GT_GLYPH_EN
  localparam logic [7:0] GT_GLYPH = 8'hC2;
`else
  localparam logic [7:0] GT_GLYPH = 8'hFF;
`endif
  unit2_compare_display dut (
    .clk(clk), .rst(rst), .SW(SW), .LEDR(LEDR),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_reset(input string tag);
    chk({tag, ".hex0"}, {24'b0, HEX0}, 32'hFF);
    chk({tag, ".hex1"}, {24'b0, HEX1}, 32'hFF);
    chk({tag, ".hex2"}, {24'b0, HEX2}, 32'hFF);
    chk({tag, ".hex3"}, {24'b0, HEX3}, 32'hFF);
    chk({tag, ".hex4"}, {24'b0, HEX4}, 32'hFF);
    chk({tag, ".hex5"}, {24'b0, HEX5}, 32'hFF);
    chk({tag, ".ledr"}, {22'b0, LEDR}, 32'h0);
  endtask
  task automatic check_out(input string tag, input logic [9:0] sw);
    int a, b;
    logic [7:0] glyph;
    logic [9:0] leds;
    a = int'(sw[7:4]);
    b = int'(sw[3:0]);
    glyph = (a < b) ? 8'hC7 : (a == b) ? 8'h86 : GT_GLYPH;
    leds = '0;
    if (a > b) leds = 10'd4;
    else if (a == b) leds = 10'd2;
    else leds = 10'd1;
    chk({tag, ".hex5"}, {24'b0, HEX5}, {24'b0, digit[a]});
    chk({tag, ".hex1"}, {24'b0, HEX1}, {24'b0, digit[b]});
    chk({tag, ".hex3"}, {24'b0, HEX3}, {24'b0, glyph});
    chk({tag, ".ledr"}, {22'b0, LEDR}, {22'b0, leds});
    chk({tag, ".blanks"}, {8'b0, HEX0, HEX2, HEX4}, 32'h00FFFFFF);
  endtask
  task automatic apply(input logic [9:0] sw);
    @(negedge clk);
    SW = sw;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [9:0] sw;
    int order [256];
    SW = 10'($urandom);
    #12;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b0;
    SW = 10'h001;
    @(posedge clk);
    #1;
    check_out("first", 10'h001);
    chk("first.exact_ledr", {22'b0, LEDR}, 32'h1);
    apply(10'h0AA);
    check_out("a_eq_a", 10'h0AA);
    chk("a_eq_a.hex3", {24'b0, HEX3}, 32'h86);
    apply(10'h0A1);
    check_out("a_gt_1", 10'h0A1);
    chk("a_gt_1.hex3", {24'b0, HEX3}, {24'b0, GT_GLYPH});
    apply(10'h000);
    chk("zero_eq.hex3", {24'b0, HEX3}, 32'h86);
    apply(10'h0F0);
    chk("f_gt_0.ledr", {22'b0, LEDR}, 32'h4);
    apply(10'h00F);
    chk("0_lt_f.hex3", {24'b0, HEX3}, 32'hC7);
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j;
      int t;
      j = int'($urandom_range(0, i));
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      sw = {2'($urandom), 8'(order[i])};
      apply(sw);
      check_out("sweep", sw);
      if (i == 128) begin
        #2;
        rst = 1'b1;
        #1;
        check_reset("mid_reset");
        @(posedge clk);
        #1;
        check_reset("mid_reset_held");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_out("recover", sw);
      end
    end
    for (int k = 0; k < 4; k++) begin
      sw = {2'(k), 8'h33};
      apply(sw);
      check_out("sw98", sw);
      chk("sw98.hex3", {24'b0, HEX3}, 32'h86);
    end
    for (int i = 0; i < 200; i++) begin
      sw = 10'($urandom);
      apply(sw);
      check_out("rand", sw);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
